two_s_complement: RTL and testbench

Registered, streaming two's-complement negation unit: each accepted WIDTH-bit word is replaced by its arithmetic negative (bitwise invert plus one). It sits on a valid/ready datapath, for example in front of a subtractor or a sign-magnitude converter. It also reports zero-result and overflow flags alongside each output word.

---
 rtl/two_s_complement.sv | 84 ++++++++
 tb/tb_two_s_complement.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/two_s_complement.sv
// Registered streaming two's-complement negation with zero/overflow flags on a valid/ready path.
// Define TWO_S_COMPLEMENT_SAT_EN to saturate the most negative operand instead of wrapping.
module two_s_complement #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_zero,
   output logic             out_ovf
);

   // state | meaning
   // EMPTY | no result held, out_valid=0
   // FULL  | result slot holds a word, out_valid=1
   localparam logic EMPTY = 1'b0;
   localparam logic FULL  = 1'b1;

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

   logic             state;
   logic             accept;
   logic             ovf_now;
   logic [WIDTH-1:0] inv;
   logic [WIDTH-1:0] neg;
   logic [WIDTH-1:0] carry;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] data_q;
   logic             zero_q;
   logic             ovf_q;

   // Increment of the inverted operand; carry out of the MSB is never formed.
   assign inv      = ~in_data;
   assign carry[0] = 1'b1;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      assign neg[i] = inv[i] ^ carry[i];
      if (i < WIDTH - 1) begin : g_carry
         assign carry[i+1] = inv[i] & carry[i];
      end
   end

   assign ovf_now = (in_data == MOST_NEG);

`ifdef TWO_S_COMPLEMENT_SAT_EN
   assign result = ovf_now ? MOST_POS : neg;
`else
   assign result = neg;
`endif

   assign out_valid = (state == FULL);
   assign in_ready  = (state == EMPTY) || out_ready;
   assign accept    = in_valid && in_ready;

   // The slot only loads on accept, so in_data is never sampled while in_valid=0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= EMPTY;
         data_q <= '0;
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         if (accept) begin
            state  <= FULL;
            data_q <= result;
            zero_q <= (result == '0);
            ovf_q  <= ovf_now;
         end else if (out_ready) begin
            state  <= EMPTY;
         end
      end
   end

   assign out_data = data_q;
   assign out_zero = zero_q;
   assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_two_s_complement.sv
// Bench for two_s_complement: scoreboard of negation results plus scenario tasks for
// reset, sweep, overflow, backpressure, stalled streaming, mid-run reset and an 8-bit instance.
module tb_two_s_complement;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic       out_zero;
   logic       out_ovf;

   logic       in8_valid;
   logic       in8_ready;
   logic [7:0] in8_data;
   logic       out8_valid;
   logic       out8_ready;
   logic [7:0] out8_data;
   logic       out8_zero;
   logic       out8_ovf;

   int tests = 0;
   int fails = 0;

   logic [5:0] exp_q[$];
   logic [3:0] obs_q[$];
   logic [3:0] words[3];

   two_s_complement #(.WIDTH(4)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_zero (out_zero),
      .out_ovf  (out_ovf)
   );

   two_s_complement #(.WIDTH(8)) u_dut8 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in8_valid),
      .in_ready (in8_ready),
      .in_data  (in8_data),
      .out_valid(out8_valid),
      .out_ready(out8_ready),
      .out_data (out8_data),
      .out_zero (out8_zero),
      .out_ovf  (out8_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: arithmetic negation modulo 16, with the most negative value special-cased.
   function automatic logic [5:0] model(input logic [3:0] d);
      logic [3:0] r;
      r = 4'(5'd16 - {1'b0, d});
`ifdef TWO_S_COMPLEMENT_SAT_EN
      if (d == 4'b1000) r = 4'b0111;
`endif
      return {r, (r == 4'b0000), (d == 4'b1000)};
   endfunction

   // Pop on output handshake, push on input handshake, both sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            tests++;
            obs_q.push_back(out_data);
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL sb_unexpected: got data=%b zero=%b ovf=%b, required no output", out_data, out_zero, out_ovf);
            end else begin
               logic [5:0] e;
               e = exp_q.pop_front();
               if ({out_data, out_zero, out_ovf} !== e) begin
                  fails++;
                  $display("FAIL sb_result: got data=%b zero=%b ovf=%b, required data=%b zero=%b ovf=%b",
                           out_data, out_zero, out_ovf, e[5:2], e[1], e[0]);
               end
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(in_data));
      end
   end

   task automatic drain(output bit ok);
      int n;
      n = 0;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      while (exp_q.size() != 0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      ok = (exp_q.size() == 0) && !out_valid;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b1; in_data = 4'b0011; out_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      tests++;
      if ({out_valid, out_data, out_zero, out_ovf} !== 7'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_state: got valid=%b data=%b zero=%b ovf=%b ready=%b, required 0 0000 0 0 ready=1",
                  out_valid, out_data, out_zero, out_ovf, in_ready);
      end
      in_valid = 1'b0; rst_n = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_discard: got out_valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_sweep;
      bit ok;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1; in_data = 4'(i);
         @(posedge clk); #1;
         if (i == 0) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== 4'b0000 || out_zero !== 1'b1 || out_ovf !== 1'b0) begin
               fails++;
               $display("FAIL sweep_latency_zero: got valid=%b data=%b zero=%b ovf=%b, required 1 0000 1 0",
                        out_valid, out_data, out_zero, out_ovf);
            end
         end
      end
      in_valid = 1'b0; in_data = 4'bxxxx;
      drain(ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL sweep_drain: got %0d pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_overflow;
      bit ok;
      logic [3:0] want;
`ifdef TWO_S_COMPLEMENT_SAT_EN
      want = 4'b0111;
`else
      want = 4'b1000;
`endif
      out_ready = 1'b1; in_valid = 1'b1; in_data = 4'b1000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      tests++;
      if (out_valid !== 1'b1 || out_data !== want || out_ovf !== 1'b1 || out_zero !== 1'b0) begin
         fails++;
         $display("FAIL overflow: got valid=%b data=%b ovf=%b zero=%b, required 1 %b 1 0",
                  out_valid, out_data, out_ovf, out_zero, want);
      end
      drain(ok);
   endtask

   task automatic test_backpressure;
      bit ok;
      out_ready = 1'b0; in_valid = 1'b1; in_data = 4'b0101;
      @(posedge clk); #1;
      in_data = 4'b0110;
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (out_valid !== 1'b1 || out_data !== 4'b1011 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold%0d: got valid=%b data=%b in_ready=%b, required 1 1011 0",
                     k, out_valid, out_data, in_ready);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      tests++;
      if (out_valid !== 1'b1 || out_data !== 4'b1010) begin
         fails++;
         $display("FAIL bp_release: got valid=%b data=%b, required 1 1010", out_valid, out_data);
      end
      drain(ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL bp_drain: got %0d pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_back_to_back;
      bit ok;
      bit acc;
      int idx;
      int cyc;
      words[0] = 4'b0001; words[1] = 4'b0010; words[2] = 4'b0011;
      obs_q.delete();
      idx = 0; cyc = 0;
      while (idx < 3 && cyc < 40) begin
         in_valid  = 1'b1;
         in_data   = words[idx];
         out_ready = ((cyc % 2) == 1);
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         if (acc) idx++;
         cyc++;
      end
      drain(ok);
      tests++;
      if (obs_q.size() != 3 || obs_q[0] !== 4'b1111 || obs_q[1] !== 4'b1110 || obs_q[2] !== 4'b1101) begin
         fails++;
         $display("FAIL b2b_sequence: got %0d words first=%b, required 3 words 1111 1110 1101",
                  obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 4'bxxxx);
      end
   endtask

   task automatic test_reset_mid;
      bit ok;
      out_ready = 1'b0; in_valid = 1'b1; in_data = 4'b1001;
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = 4'bxxxx;
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || out_data !== 4'b0111) begin
         fails++;
         $display("FAIL mid_hold_x: got valid=%b data=%b, required 1 0111", out_valid, out_data);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      tests++;
      if ({out_valid, out_data, out_zero, out_ovf} !== 7'b0) begin
         fails++;
         $display("FAIL mid_reset: got valid=%b data=%b zero=%b ovf=%b, required 0 0000 0 0",
                  out_valid, out_data, out_zero, out_ovf);
      end
      rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 4'b0100;
      @(posedge clk); #1;
      in_valid = 1'b0;
      tests++;
      if (out_valid !== 1'b1 || out_data !== 4'b1100) begin
         fails++;
         $display("FAIL mid_after: got valid=%b data=%b, required 1 1100", out_valid, out_data);
      end
      drain(ok);
   endtask

   task automatic test_width8;
      logic [7:0] want;
`ifdef TWO_S_COMPLEMENT_SAT_EN
      want = 8'h7F;
`else
      want = 8'h80;
`endif
      in8_valid = 1'b1; in8_data = 8'h01;
      @(posedge clk); #1;
      tests++;
      if (out8_valid !== 1'b1 || out8_data !== 8'hFF || out8_ovf !== 1'b0) begin
         fails++;
         $display("FAIL w8_one: got valid=%b data=%h ovf=%b, required 1 ff 0", out8_valid, out8_data, out8_ovf);
      end
      in8_data = 8'h80;
      @(posedge clk); #1;
      in8_valid = 1'b0;
      tests++;
      if (out8_valid !== 1'b1 || out8_data !== want || out8_ovf !== 1'b1) begin
         fails++;
         $display("FAIL w8_minneg: got valid=%b data=%h ovf=%b, required 1 %h 1", out8_valid, out8_data, out8_ovf, want);
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = 4'b0000; out_ready = 1'b0;
      in8_valid = 1'b0; in8_data = 8'h00; out8_ready = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_sweep();
      test_overflow();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_width8();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

endmodule
